// File: rtl/core_pkg.sv
// Shared encodings for the core_control / memory-controller arbitration slice.
package core_pkg;

  localparam int COND_W     = 3;
  localparam int DATA_LEN_W = 6;

  typedef logic [COND_W-1:0]     cond_t;
  typedef logic [DATA_LEN_W-1:0] data_len_t;

  localparam cond_t COND_NONE  = 3'b000;
  localparam cond_t COND_INPUT = 3'b100;
  localparam cond_t COND_MEM   = 3'b010;
  localparam cond_t COND_REG   = 3'b001;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, cyclically.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic             valid
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDX_W'((int'(ptr) + k) % NREQ);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mc_arbiter.sv
// Round-robin owner arbitration of one memory controller among NREQ core_control blocks.
module mc_arbiter
  import core_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                       ctrl_clk,
  input  logic                       ctrl_reset,
  input  logic [COND_W*NREQ-1:0]     req_data_contition,
  input  logic [DATA_LEN_W*NREQ-1:0] req_data_length,
  output logic [NREQ-1:0]            req_mc_done,
  output logic [NREQ-1:0]            req_mc_data_done,
  output logic [COND_W-1:0]          mc_data_contition,
  output logic [DATA_LEN_W-1:0]      mc_data_length,
  input  logic                       mc_done,
  input  logic                       mc_data_done,
  output logic [NREQ-1:0]            arb_grant,
  output logic                       arb_busy,
  output logic                       arb_timeout_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [1:0]       state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_next;
  logic [CNT_W-1:0] hold_cnt;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  pick_gnt;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  cond_t            owner_cond;
  logic             wd_hit;
  cond_t            cond_arr [NREQ];
  data_len_t        len_arr  [NREQ];

  always_comb begin
    req      = '0;
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      cond_arr[i] = req_data_contition[COND_W*i +: COND_W];
      len_arr[i]  = req_data_length[DATA_LEN_W*i +: DATA_LEN_W];
      req[i]      = |cond_arr[i];
      if (pick_gnt[i]) pick_idx = IDX_W'(i);
    end
  end

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  assign owner_cond = cond_arr[owner];
  assign wd_hit     = (TIMEOUT != 0) && (hold_cnt == CNT_W'(TIMEOUT - 1));
  assign ptr_next   = (owner == IDX_W'(NREQ - 1)) ? '0 : owner + IDX_W'(1);

  always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state           <= IDLE;
      arb_grant       <= '0;
      owner           <= '0;
      ptr             <= '0;
      hold_cnt        <= '0;
      mc_data_length  <= '0;
      arb_timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            arb_grant      <= pick_gnt;
            owner          <= pick_idx;
            mc_data_length <= len_arr[pick_idx];
            hold_cnt       <= '0;
            state          <= GRANT;
          end
        end
        GRANT: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (owner_cond == COND_NONE || wd_hit) begin
            // A normal end of job wins over a watchdog hit in the same cycle.
            if (owner_cond != COND_NONE) arb_timeout_err <= 1'b1;
            arb_grant <= '0;
            ptr       <= ptr_next;
            state     <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign arb_busy = (state == GRANT);

  always_comb begin
    mc_data_contition = COND_NONE;
    req_mc_done       = '0;
    req_mc_data_done  = '0;
    if (arb_busy) begin
      mc_data_contition       = owner_cond;
      req_mc_done[owner]      = mc_done;
      req_mc_data_done[owner] = mc_data_done;
    end
  end

endmodule

// File: tb/tb_mc_arbiter.sv
// Self-checking bench for mc_arbiter: vector table plus watchdog and fairness sequences.
module tb_mc_arbiter;

  logic        ctrl_clk = 1'b0;
  logic        ctrl_reset = 1'b1;
  logic [11:0] req_data_contition = '0;
  logic [23:0] req_data_length = {6'd7, 6'd12, 6'd3, 6'd9};
  logic [3:0]  req_mc_done;
  logic [3:0]  req_mc_data_done;
  logic [2:0]  mc_data_contition;
  logic [5:0]  mc_data_length;
  logic        mc_done = 1'b0;
  logic        mc_data_done = 1'b0;
  logic [3:0]  arb_grant;
  logic        arb_busy;
  logic        arb_timeout_err;

  mc_arbiter #(
    .NREQ    (4),
    .IDX_W   (2),
    .TIMEOUT (8)
  ) dut (
    .ctrl_clk           (ctrl_clk),
    .ctrl_reset         (ctrl_reset),
    .req_data_contition (req_data_contition),
    .req_data_length    (req_data_length),
    .req_mc_done        (req_mc_done),
    .req_mc_data_done   (req_mc_data_done),
    .mc_data_contition  (mc_data_contition),
    .mc_data_length     (mc_data_length),
    .mc_done            (mc_done),
    .mc_data_done       (mc_data_done),
    .arb_grant          (arb_grant),
    .arb_busy           (arb_busy),
    .arb_timeout_err    (arb_timeout_err)
  );

  always #5 ctrl_clk = ~ctrl_clk;

  // exp = {grant, mc_cond, mc_len, req_done, req_data_done, busy, err}
  typedef struct {
    logic        rst;
    logic [11:0] cond;
    logic        d;
    logic        dd;
    logic [22:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [22:0] exp_q[$];
  logic [3:0]  grant_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic vec_t mk(input logic rst, input logic [11:0] cond, input logic d,
                              input logic dd, input logic [3:0] g, input logic [2:0] mcc,
                              input logic [5:0] mcl, input logic [3:0] rd,
                              input logic [3:0] rdd, input logic busy, input logic err);
    vec_t v;
    v.rst  = rst;
    v.cond = cond;
    v.d    = d;
    v.dd   = dd;
    v.exp  = {g, mcc, mcl, rd, rdd, busy, err};
    return v;
  endfunction

  task automatic step(input string name, input int idx, input vec_t v);
    logic [22:0] got;
    logic [22:0] want;
    @(negedge ctrl_clk);
    ctrl_reset         = v.rst;
    req_data_contition = v.cond;
    mc_done            = v.d;
    mc_data_done       = v.dd;
    exp_q.push_back(v.exp);
    #1;
    got  = {arb_grant, mc_data_contition, mc_data_length, req_mc_done, req_mc_data_done,
            arb_busy, arb_timeout_err};
    want = exp_q.pop_front();
    n_checks++;
    if (got === want) n_pass++;
    else
      $display("FAIL %s[%0d]: got gnt=%b cond=%b len=%0d done=%b ddone=%b busy=%b err=%b, want gnt=%b cond=%b len=%0d done=%b ddone=%b busy=%b err=%b",
               name, idx, got[22:19], got[18:16], got[15:10], got[9:6], got[5:2], got[1],
               got[0], want[22:19], want[18:16], want[15:10], want[9:6], want[5:2], want[1],
               want[0]);
  endtask

  initial begin
    logic [3:0]  got_g;
    logic [3:0]  want_g;
    logic [11:0] all_req;

    // reset state
    tbl.push_back(mk(1, 12'b000_000_000_000, 0, 0, 4'b0000, 3'b000, 6'd0, 4'b0, 4'b0, 0, 0));
    // single request from 2, length 12
    tbl.push_back(mk(0, 12'b000_100_000_000, 0, 0, 4'b0000, 3'b000, 6'd0, 4'b0, 4'b0, 0, 0));
    tbl.push_back(mk(0, 12'b000_100_000_000, 1, 0, 4'b0100, 3'b100, 6'd12, 4'b0100, 4'b0, 1, 0));
    tbl.push_back(mk(0, 12'b000_100_000_000, 0, 1, 4'b0100, 3'b100, 6'd12, 4'b0, 4'b0100, 1, 0));
    tbl.push_back(mk(0, 12'b000_000_000_000, 0, 0, 4'b0100, 3'b000, 6'd12, 4'b0, 4'b0, 1, 0));
    tbl.push_back(mk(0, 12'b000_000_000_000, 1, 1, 4'b0000, 3'b000, 6'd12, 4'b0, 4'b0, 0, 0));
    // contention 0 and 3, pointer 0
    tbl.push_back(mk(1, 12'b000_000_000_000, 0, 0, 4'b0000, 3'b000, 6'd0, 4'b0, 4'b0, 0, 0));
    tbl.push_back(mk(0, 12'b100_000_000_100, 0, 0, 4'b0000, 3'b000, 6'd0, 4'b0, 4'b0, 0, 0));
    tbl.push_back(mk(0, 12'b100_000_000_100, 0, 0, 4'b0001, 3'b100, 6'd9, 4'b0, 4'b0, 1, 0));
    tbl.push_back(mk(0, 12'b100_000_000_000, 0, 0, 4'b0001, 3'b000, 6'd9, 4'b0, 4'b0, 1, 0));
    tbl.push_back(mk(0, 12'b100_000_000_000, 0, 0, 4'b0000, 3'b000, 6'd9, 4'b0, 4'b0, 0, 0));
    tbl.push_back(mk(0, 12'b100_000_000_000, 0, 0, 4'b0000, 3'b000, 6'd9, 4'b0, 4'b0, 0, 0));
    tbl.push_back(mk(0, 12'b100_000_000_000, 1, 0, 4'b1000, 3'b100, 6'd7, 4'b1000, 4'b0, 1, 0));
    tbl.push_back(mk(0, 12'b000_000_000_000, 0, 0, 4'b1000, 3'b000, 6'd7, 4'b0, 4'b0, 1, 0));
    tbl.push_back(mk(0, 12'b000_000_000_000, 0, 0, 4'b0000, 3'b000, 6'd7, 4'b0, 4'b0, 0, 0));
    // job continuity on owner 1 while 0 waits
    tbl.push_back(mk(1, 12'b000_000_000_000, 0, 0, 4'b0000, 3'b000, 6'd0, 4'b0, 4'b0, 0, 0));
    tbl.push_back(mk(0, 12'b000_000_100_000, 0, 0, 4'b0000, 3'b000, 6'd0, 4'b0, 4'b0, 0, 0));
    tbl.push_back(mk(0, 12'b000_000_100_100, 1, 0, 4'b0010, 3'b100, 6'd3, 4'b0010, 4'b0, 1, 0));
    tbl.push_back(mk(0, 12'b000_000_010_100, 0, 1, 4'b0010, 3'b010, 6'd3, 4'b0, 4'b0010, 1, 0));
    tbl.push_back(mk(0, 12'b000_000_001_100, 1, 0, 4'b0010, 3'b001, 6'd3, 4'b0010, 4'b0, 1, 0));
    tbl.push_back(mk(0, 12'b000_000_010_100, 0, 1, 4'b0010, 3'b010, 6'd3, 4'b0, 4'b0010, 1, 0));
    tbl.push_back(mk(0, 12'b000_000_001_100, 0, 0, 4'b0010, 3'b001, 6'd3, 4'b0, 4'b0, 1, 0));
    tbl.push_back(mk(0, 12'b000_000_000_100, 0, 0, 4'b0010, 3'b000, 6'd3, 4'b0, 4'b0, 1, 0));
    tbl.push_back(mk(0, 12'b000_000_000_100, 1, 0, 4'b0000, 3'b000, 6'd3, 4'b0, 4'b0, 0, 0));
    tbl.push_back(mk(0, 12'b000_000_000_100, 1, 0, 4'b0000, 3'b000, 6'd3, 4'b0, 4'b0, 0, 0));
    tbl.push_back(mk(0, 12'b000_000_000_100, 1, 0, 4'b0001, 3'b100, 6'd9, 4'b0001, 4'b0, 1, 0));
    // reset mid-grant, then pointer must be back at 0
    tbl.push_back(mk(1, 12'b000_000_000_100, 1, 0, 4'b0000, 3'b000, 6'd0, 4'b0, 4'b0, 0, 0));
    tbl.push_back(mk(0, 12'b000_100_000_100, 0, 0, 4'b0000, 3'b000, 6'd0, 4'b0, 4'b0, 0, 0));
    tbl.push_back(mk(0, 12'b000_100_000_100, 0, 0, 4'b0001, 3'b100, 6'd9, 4'b0, 4'b0, 1, 0));
    tbl.push_back(mk(0, 12'b000_100_000_000, 0, 0, 4'b0001, 3'b000, 6'd9, 4'b0, 4'b0, 1, 0));
    tbl.push_back(mk(0, 12'b000_100_000_000, 0, 0, 4'b0000, 3'b000, 6'd9, 4'b0, 4'b0, 0, 0));
    tbl.push_back(mk(0, 12'b000_100_000_000, 0, 0, 4'b0000, 3'b000, 6'd9, 4'b0, 4'b0, 0, 0));
    tbl.push_back(mk(0, 12'b000_100_000_000, 0, 0, 4'b0100, 3'b100, 6'd12, 4'b0, 4'b0, 1, 0));
    tbl.push_back(mk(0, 12'b000_000_000_000, 0, 0, 4'b0100, 3'b000, 6'd12, 4'b0, 4'b0, 1, 0));
    tbl.push_back(mk(0, 12'b000_000_000_000, 0, 0, 4'b0000, 3'b000, 6'd12, 4'b0, 4'b0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) step("vec", i, tbl[i]);

    // Owner ends its job on the last allowed cycle: release, no watchdog flag.
    step("wd_edge", 0, mk(1, 12'b000_000_000_000, 0, 0, 4'b0, 3'b000, 6'd0, 4'b0, 4'b0, 0, 0));
    step("wd_edge", 1, mk(0, 12'b000_000_010_000, 0, 0, 4'b0, 3'b000, 6'd0, 4'b0, 4'b0, 0, 0));
    for (int k = 0; k < 7; k++)
      step("wd_edge_hold", k,
           mk(0, 12'b000_000_010_000, 0, 0, 4'b0010, 3'b010, 6'd3, 4'b0, 4'b0, 1, 0));
    step("wd_edge", 2, mk(0, 12'b000_000_000_000, 0, 0, 4'b0010, 3'b000, 6'd3, 4'b0, 4'b0, 1, 0));
    step("wd_edge", 3, mk(0, 12'b000_000_000_000, 0, 0, 4'b0000, 3'b000, 6'd3, 4'b0, 4'b0, 0, 0));
    step("wd_edge", 4, mk(0, 12'b000_000_000_000, 0, 0, 4'b0000, 3'b000, 6'd3, 4'b0, 4'b0, 0, 0));

    // Watchdog: owner 1 holds 010 forever, requester 3 waiting.
    step("wd", 0, mk(1, 12'b000_000_000_000, 0, 0, 4'b0, 3'b000, 6'd0, 4'b0, 4'b0, 0, 0));
    step("wd", 1, mk(0, 12'b010_000_010_000, 0, 0, 4'b0, 3'b000, 6'd0, 4'b0, 4'b0, 0, 0));
    for (int k = 0; k < 8; k++)
      step("wd_hold", k,
           mk(0, 12'b010_000_010_000, 0, 0, 4'b0010, 3'b010, 6'd3, 4'b0, 4'b0, 1, 0));
    step("wd", 2, mk(0, 12'b010_000_010_000, 0, 0, 4'b0000, 3'b000, 6'd3, 4'b0, 4'b0, 0, 1));
    step("wd", 3, mk(0, 12'b010_000_010_000, 0, 0, 4'b0000, 3'b000, 6'd3, 4'b0, 4'b0, 0, 1));
    step("wd", 4, mk(0, 12'b010_000_010_000, 0, 0, 4'b1000, 3'b010, 6'd7, 4'b0, 4'b0, 1, 1));
    step("wd", 5, mk(0, 12'b000_000_000_000, 0, 0, 4'b1000, 3'b000, 6'd7, 4'b0, 4'b0, 1, 1));
    step("wd", 6, mk(0, 12'b000_000_000_000, 0, 0, 4'b0000, 3'b000, 6'd7, 4'b0, 4'b0, 0, 1));

    // Fairness: all four request continuously for eight jobs.
    step("fair_rst", 0, mk(1, 12'b000_000_000_000, 0, 0, 4'b0, 3'b000, 6'd0, 4'b0, 4'b0, 0, 0));
    all_req            = 12'b100_100_100_100;
    ctrl_reset         = 1'b0;
    req_data_contition = all_req;
    for (int j = 0; j < 8; j++) begin
      want_g = 4'b0001 << (j % 4);
      grant_q.push_back(want_g);
      got_g = '0;
      for (int c = 0; c < 10; c++) begin
        @(negedge ctrl_clk);
        #1;
        if (arb_grant != '0) begin
          got_g = arb_grant;
          break;
        end
      end
      want_g = grant_q.pop_front();
      n_checks++;
      if (got_g === want_g) n_pass++;
      else $display("FAIL fair[%0d]: got grant=%b want grant=%b", j, got_g, want_g);
      for (int i = 0; i < 4; i++) if (got_g[i]) req_data_contition[3*i +: 3] = 3'b000;
      @(negedge ctrl_clk);
      #1;
      req_data_contition = all_req;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_arbiter.md
Name: mc_arbiter

Overview:
- Shares one memory controller between NREQ core_control instances, so several cores can run store, transfer and process jobs against a single memory.
- A requester owns the memory controller for a whole job: from the cycle its data condition leaves 000 until it returns to 000.
- Grants are round-robin.
- The arbiter forwards the owner's data condition and length to the memory controller and routes mc_done / mc_data_done back only to the owner. Non-owners stall naturally because they see no done.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDX_W, 2, index width; equals clog2(NREQ).
- TIMEOUT, 1023, maximum cycles one grant may be held; 0 disables the watchdog.

Ports:
- ctrl_clk  in  1  clock
- ctrl_reset  in  1  asynchronous active-high reset
- req_data_contition  in  3*NREQ  per-requester data condition; requester i uses bits [3i+2:3i]
- req_data_length  in  6*NREQ  per-requester data length; requester i uses bits [6i+5:6i]
- req_mc_done  out  NREQ  mc_done routed to the owner only
- req_mc_data_done  out  NREQ  mc_data_done routed to the owner only
- mc_data_contition  out  3  condition presented to the memory controller
- mc_data_length  out  6  length presented to the memory controller
- mc_done  in  1  from the memory controller
- mc_data_done  in  1  from the memory controller
- arb_grant  out  NREQ  one-hot owner; all zero when no owner
- arb_busy  out  1  high in GRANT
- arb_timeout_err  out  1  sticky watchdog flag

Behaviour:
- Clock and reset: single clock ctrl_clk. ctrl_reset is asynchronous and active-high.
- Reset values:
  - state IDLE, arb_grant 0, arb_busy 0, arb_timeout_err 0
  - priority pointer 0, hold counter 0
  - mc_data_contition 000, mc_data_length 0, req_mc_done 0, req_mc_data_done 0
- Request definition: requester i requests when its condition is not 000.
- IDLE:
  - If any request is present, pick the first requester at or after the pointer (cyclic order).
  - Register arb_grant, latch that requester's length into mc_data_length, clear the hold counter, go to GRANT.
  - Grant appears one cycle after the request is sampled.
- GRANT:
  - mc_data_contition is a combinational pass-through of the owner's condition (zero added latency).
  - mc_data_length is held from the grant cycle.
  - req_mc_done[owner] = mc_done and req_mc_data_done[owner] = mc_data_done, combinationally; all other bits are 0.
  - The hold counter increments every cycle.
  - Owner condition returns to 000: go to RELEASE.
  - TIMEOUT != 0 and counter == TIMEOUT-1: set arb_timeout_err and force RELEASE.
  - Release takes priority if both happen in the same cycle; the flag is not set then.
- RELEASE (exactly 1 cycle):
  - arb_grant 0, mc_data_contition 000, all done outputs 0.
  - Pointer becomes owner+1, modulo NREQ.
  - Go to IDLE.
  - The gap guarantees the memory controller sees 000 between owners.
- Outside GRANT: mc_data_contition is forced to 000, and mc_done / mc_data_done are dropped.
- Requests arriving mid-grant wait. Simultaneous requests are resolved only by the pointer.
- arb_timeout_err is cleared only by reset.
- Reset mid-grant: the block returns to the reset state immediately. The memory controller is expected to be reset on the same signal.
- Condition encodings (100 store, 010 mem-to-reg, 001 processing) are not interpreted, only forwarded.

Decomposition:
- Shared package (core_pkg):
  - condition encodings COND_NONE, COND_INPUT, COND_MEM, COND_REG
  - arbiter state encodings IDLE, GRANT, RELEASE
  - DATA_LEN_W = 6 and COND_W = 3
- Sub-module rr_pick: combinational round-robin picker. Inputs: request vector and pointer. Outputs: one-hot grant and valid.

Test Plan:
- Single request: requester 2 condition 100, length 6'd12 -> arb_grant 0100 next cycle; mc_data_length 12; mc_data_contition 100. mc_done pulse reaches req_mc_done[2] only.
- Contention: requesters 0 and 3 raise 100 in the same cycle with pointer 0 -> 0 is granted first. After 0 returns to 000, one RELEASE cycle with mc_data_contition 000, then 3 is granted.
- Fairness: all 4 request continuously for 8 jobs -> grant order 0,1,2,3,0,1,2,3.
- Job continuity: owner 1 steps 100 -> 010 -> 001 -> 010 -> 001 -> 000 -> grant held throughout; req_mc_data_done[1] mirrors mc_data_done. Requester 0 requesting meanwhile sees req_mc_done[0] = 0.
- Watchdog: TIMEOUT = 8, owner holds 010 forever -> forced release after 8 GRANT cycles; arb_timeout_err = 1 and stays set; next requester is then granted.
- Reset mid-grant: assert ctrl_reset in GRANT -> all outputs return to reset values immediately (asynchronously); pointer 0.
